// File: rtl/lane_mux_nxm.sv
// lane_mux_nxm: narrows NUM_IN-lane beats to NUM_OUT-lane groups.
// Beats are queued in a DEPTH-entry FIFO. Each beat is then emitted as
// RATIO = NUM_IN/NUM_OUT consecutive groups.
//
// Handshake semantics:
//   Input side: a beat transfers at posedge when in_ready && |in_valid.
//     in_ready comes only from registered state. It never waits on in_valid.
//   Output side: a group transfers at posedge when out_beat && out_ready.
//     A presented group is held stable until it transfers.
//     out_ready has no effect while out_beat is low.
module lane_mux_nxm #(
    parameter int W       = 8,
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 2,
    parameter int DEPTH   = 4,
    parameter int COMPACT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_IN*W-1:0]    in_data,
    input  logic [NUM_IN-1:0]      in_valid,
    output logic                   in_ready,
    output logic [NUM_OUT*W-1:0]   out_data,
    output logic [NUM_OUT-1:0]     out_valid,
    output logic                   out_beat,
    input  logic                   out_ready,
    output logic                   ovf
);
    localparam int RATIO = NUM_IN / NUM_OUT;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int PW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int GW    = NUM_OUT * W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    generate
        if (NUM_IN % NUM_OUT != 0) begin : g_ratio_check
            $error("lane_mux_nxm: NUM_IN must be a multiple of NUM_OUT");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
            $error("lane_mux_nxm: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    logic [NUM_IN*W-1:0] mem_data  [DEPTH];
    logic [NUM_IN-1:0]   mem_valid [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [PW-1:0]       phase;      // lowest group index still to be emitted
    logic                rst_done;   // low while reset is held, so in_ready stays low

    logic [NUM_IN*W-1:0] head_data;
    logic [NUM_IN-1:0]   head_valid;
    logic [RATIO-1:0]    gnz;        // groups of the head that are eligible for output
    logic [PW-1:0]       cur_grp;    // group presented this cycle
    logic                has_next;   // another eligible group follows cur_grp
    logic                push;
    logic                adv;
    logic                pop;

    assign head_data  = mem_data[rd_ptr];
    assign head_valid = mem_valid[rd_ptr];
    assign out_beat   = (count != '0);
    assign in_ready   = rst_done && (count < DEPTH_C);
    assign push       = in_ready && (|in_valid);
    assign adv        = out_beat && out_ready;
    assign pop        = adv && !has_next;

    // Mark eligible groups. In compact mode, a group with all lane valids zero is skipped.
    always_comb begin
        gnz = '1;
        for (int g = 0; g < RATIO; g++) begin
            if (COMPACT != 0) gnz[g] = |head_valid[g*NUM_OUT +: NUM_OUT];
        end
    end

    // Pick the first eligible group at or after phase.
    // Then check whether an eligible group follows it.
    always_comb begin
        cur_grp  = phase;
        has_next = 1'b0;
        for (int g = RATIO - 1; g >= 0; g--) begin
            if (g >= int'(phase) && gnz[g]) cur_grp = PW'(g);
        end
        for (int g = 0; g < RATIO; g++) begin
            if (g > int'(cur_grp) && gnz[g]) has_next = 1'b1;
        end
    end

    // Select the presented group. Outputs are zero while the FIFO is empty.
    always_comb begin
        out_data  = '0;
        out_valid = '0;
        if (out_beat) begin
            for (int g = 0; g < RATIO; g++) begin
                if (cur_grp == PW'(g)) begin
                    out_data  = head_data[g*GW +: GW];
                    out_valid = head_valid[g*NUM_OUT +: NUM_OUT];
                end
            end
        end
    end

    // Write the FIFO storage. Entries are not reset: stale contents are never presented.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr]  <= in_data;
            mem_valid[wr_ptr] <= in_valid;
        end
    end

    // Update pointers, occupancy, group phase and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            phase    <= '0;
            rst_done <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
            if (adv) phase <= pop ? '0 : cur_grp + PW'(1);
            if ((|in_valid) && !in_ready) ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lane_mux_nxm.sv
// tb_lane_mux_nxm: directed bench for lane_mux_nxm.
// It runs a COMPACT=0 instance and a COMPACT=1 instance side by side on shared inputs.
module tb_lane_mux_nxm;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic        out_ready;

    logic        in_ready0, in_ready1;
    logic [15:0] out_data0, out_data1;
    logic [1:0]  out_valid0, out_valid1;
    logic        out_beat0, out_beat1;
    logic        ovf0, ovf1;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    // Clock and reset
    always #5 clk = ~clk;

    lane_mux_nxm #(.W(8), .NUM_IN(4), .NUM_OUT(2), .DEPTH(4), .COMPACT(0)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
        .out_beat(out_beat0), .out_ready(out_ready), .ovf(ovf0)
    );

    lane_mux_nxm #(.W(8), .NUM_IN(4), .NUM_OUT(2), .DEPTH(4), .COMPACT(1)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
        .out_beat(out_beat1), .out_ready(out_ready), .ovf(ovf1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock. Checks and new inputs happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Build the beat with byte lane l = 16*(i+1)+l and queue its two expected groups.
    task automatic make_beat(input int i, output logic [31:0] beat);
        logic [7:0] b [4];
        for (int l = 0; l < 4; l++) b[l] = 8'(16 * (i + 1) + l);
        beat = {b[3], b[2], b[1], b[0]};
        exp_q.push_back({b[1], b[0]});
        exp_q.push_back({b[3], b[2]});
    endtask

    initial begin
        logic [31:0] beat;
        logic [15:0] e;
        int          pushed;
        int          budget;
        bit          saw_full;

        reset = 1'b0; in_data = 32'hDEADBEEF; in_valid = 4'hF; out_ready = 1'b1;

        // 1: reset held for 3 clocks with all lanes valid
        repeat (3) tick();
        check_eq("rst_in_ready", in_ready0, 0);
        check_eq("rst_out_beat", out_beat0, 0);
        check_eq("rst_ovf", ovf0, 0);
        check_eq("rst_out_valid", out_valid0, 0);
        check_eq("rst_out_data", out_data0, 0);
        reset = 1'b1; in_valid = 4'h0;
        tick();
        check_eq("rel_in_ready", in_ready0, 1);
        check_eq("rel_out_beat", out_beat0, 0);

        // 2: basic narrowing
        in_data = 32'h44332211; in_valid = 4'hF;
        tick();
        in_valid = 4'h0;
        check_eq("basic_g0_beat", out_beat0, 1);
        check_eq("basic_g0_data", out_data0, 16'h2211);
        check_eq("basic_g0_valid", out_valid0, 2'b11);
        check_eq("basic_c_g0_data", out_data1, 16'h2211);
        tick();
        check_eq("basic_g1_data", out_data0, 16'h4433);
        check_eq("basic_g1_valid", out_valid0, 2'b11);
        tick();
        check_eq("basic_empty", out_beat0, 0);
        check_eq("basic_c_empty", out_beat1, 0);

        // 3: backpressure fills the FIFO, and the fifth beat overflows
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            make_beat(i, beat);
            if (i == 4) begin
                void'(exp_q.pop_back());
                void'(exp_q.pop_back());
            end
            in_data = beat; in_valid = 4'hF;
            tick();
            if (i == 3) check_eq("bp_full_in_ready", in_ready0, 0);
        end
        in_valid = 4'h0;
        check_eq("bp_ovf", ovf0, 1);
        check_eq("bp_c_ovf", ovf1, 1);
        check_eq("bp_in_ready", in_ready0, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            e = exp_q.pop_front();
            check_eq("bp_drain_beat", out_beat0, 1);
            check_eq("bp_drain_data", out_data0, e);
            check_eq("bp_c_drain_data", out_data1, e);
            tick();
        end
        check_eq("bp_drained", out_beat0, 0);
        check_eq("bp_ovf_sticky", ovf0, 1);

        // 4: sparse beat, with the lower group all invalid
        in_data = 32'hDDCCBBAA; in_valid = 4'b1100;
        tick();
        in_valid = 4'h0;
        check_eq("sparse_g0_beat", out_beat0, 1);
        check_eq("sparse_g0_valid", out_valid0, 2'b00);
        check_eq("sparse_c_beat", out_beat1, 1);
        check_eq("sparse_c_valid", out_valid1, 2'b11);
        check_eq("sparse_c_data", out_data1, 16'hDDCC);
        tick();
        check_eq("sparse_g1_valid", out_valid0, 2'b11);
        check_eq("sparse_g1_data", out_data0, 16'hDDCC);
        check_eq("sparse_c_done", out_beat1, 0);
        tick();
        check_eq("sparse_done", out_beat0, 0);

        // 6: reset mid-operation, with 3 beats queued and phase = 1
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            make_beat(10 + i, beat);
            in_data = beat; in_valid = 4'hF;
            tick();
        end
        in_valid = 4'h0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("mid_phase1_data", out_data0, exp_q[1]);
        exp_q.delete();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_eq("mid_rst_beat", out_beat0, 0);
        check_eq("mid_rst_ovf", ovf0, 0);
        check_eq("mid_rst_in_ready", in_ready0, 0);
        tick();
        check_eq("mid_rel_in_ready", in_ready0, 1);
        check_eq("mid_rel_empty", out_beat0, 0);
        in_data = 32'h87654321; in_valid = 4'hF;
        tick();
        in_valid = 4'h0;
        check_eq("mid_fresh_g0", out_data0, 16'h4321);
        tick();
        check_eq("mid_stall_hold", out_data0, 16'h4321);
        check_eq("mid_stall_valid", out_valid0, 2'b11);
        out_ready = 1'b1;
        tick();
        check_eq("mid_fresh_g1", out_data0, 16'h8765);
        tick();
        check_eq("mid_fresh_empty", out_beat0, 0);

        // 5: streaming. A beat is offered whenever in_ready is high, and out_ready stays high.
        pushed = 0; budget = 0; saw_full = 1'b0;
        while ((pushed < 10 || exp_q.size() != 0 || out_beat0) && budget < 200) begin
            if (out_beat0) begin
                if (exp_q.size() == 0) check_eq("stream_extra_beat", out_beat0, 0);
                else check_eq("stream_data", out_data0, exp_q.pop_front());
            end
            if (pushed < 10 && !in_ready0) saw_full = 1'b1;
            if (pushed < 10 && in_ready0) begin
                make_beat(20 + pushed, beat);
                in_data = beat; in_valid = 4'hF;
                pushed++;
            end else begin
                in_valid = 4'h0;
            end
            tick();
            budget++;
        end
        in_valid = 4'h0;
        check_eq("stream_budget", (budget < 200) ? 1 : 0, 1);
        check_eq("stream_pushed", pushed, 10);
        check_eq("stream_left", exp_q.size(), 0);
        check_eq("stream_saw_full", saw_full, 1);
        check_eq("stream_ovf", ovf0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
